bridge_cmd_dispatch: RTL and testbench

//  - Parametrised host-command dispatcher for the APF bridge command path.
//  - Matches each incoming command word against a table of N_CHAN command codes.
//  - Pulses the matching channel's valid, then returns that channel's done/result/response to the bridge.
//  - Adds a per-command watchdog timeout, per-channel enable mask and saturating error counters.
//  - Sits between the bridge command driver and the core's command consumers.
//

---
 rtl/bridge_cmd_dispatch.sv | 125 ++++++++++++
 tb/tb_bridge_cmd_dispatch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_cmd_dispatch.sv
// Host-command dispatcher: matches the bridge command word against a code table,
// starts the matching channel and returns its completion, with a watchdog timeout,
// a per-channel enable mask and saturating error counters.
module bridge_cmd_dispatch #(
   parameter int unsigned                 N_CHAN         = 8,
   parameter int unsigned                 WORD_W         = 16,
   parameter int unsigned                 RESULT_W       = 16,
   parameter int unsigned                 RESP_W         = 32,
   parameter logic [N_CHAN*WORD_W-1:0]    CMD_WORDS      = '0,
   parameter int unsigned                 TIMEOUT_CYCLES = 0,
   parameter logic [RESULT_W-1:0]         TIMEOUT_RESULT = RESULT_W'(16'h0002),
   parameter logic [RESULT_W-1:0]         UNKNOWN_RESULT = RESULT_W'(16'h0001),
   localparam int unsigned                IDX_W          = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cmd_valid,
   input  logic [WORD_W-1:0]             cmd_word,
   output logic                          cmd_done,
   output logic [RESULT_W-1:0]           cmd_result,
   output logic [RESP_W-1:0]             cmd_response,
   input  logic [N_CHAN-1:0]             chan_enable,
   output logic [N_CHAN-1:0]             chan_valid,
   input  logic [N_CHAN-1:0]             chan_done,
   input  logic [N_CHAN*RESULT_W-1:0]    chan_result,
   input  logic [N_CHAN*RESP_W-1:0]      chan_response,
   output logic                          busy,
   output logic [IDX_W-1:0]              active_idx,
   output logic [7:0]                    timeout_count,
   output logic [7:0]                    unknown_count
);

   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, UNKNOWN} state_t;

   state_t             state;
   logic [WD_W-1:0]    wd;
   logic [N_CHAN-1:0]  hit;
   logic               any_hit;
   logic [IDX_W-1:0]   hit_idx;
   logic               done_c;
   logic               to_hit;

   // Table match against enabled channels; lowest index wins on duplicates
   always_comb begin
      hit     = '0;
      hit_idx = '0;
      for (int i = 0; i < int'(N_CHAN); i++) begin
         hit[i] = (cmd_word == CMD_WORDS[i*WORD_W +: WORD_W]) & chan_enable[i];
      end
      for (int i = int'(N_CHAN) - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = IDX_W'(i);
      end
      any_hit = |hit;
   end

   // Completion of the active channel versus watchdog expiry (channel wins a tie)
   always_comb begin
      done_c = chan_done[active_idx];
      to_hit = (TIMEOUT_CYCLES != 0) && (wd == WD_W'(TIMEOUT_CYCLES)) && !done_c;
   end

   // Response mux back to the bridge; zero whenever no completion is presented
   always_comb begin
      cmd_done     = 1'b0;
      cmd_result   = '0;
      cmd_response = '0;
      case (state)
         BUSY: begin
            if (done_c) begin
               cmd_done     = 1'b1;
               cmd_result   = chan_result[int'(active_idx)*RESULT_W +: RESULT_W];
               cmd_response = chan_response[int'(active_idx)*RESP_W +: RESP_W];
            end else if (to_hit) begin
               cmd_done     = 1'b1;
               cmd_result   = TIMEOUT_RESULT;
            end
         end
         UNKNOWN: begin
            cmd_done   = 1'b1;
            cmd_result = UNKNOWN_RESULT;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

   // Dispatch state, start pulse, watchdog and error counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         chan_valid    <= '0;
         active_idx    <= '0;
         wd            <= '0;
         timeout_count <= '0;
         unknown_count <= '0;
      end else begin
         chan_valid <= '0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (any_hit) begin
                     state      <= BUSY;
                     active_idx <= hit_idx;
                     chan_valid <= N_CHAN'(1) << hit_idx;
                     wd         <= '0;
                  end else begin
                     state <= UNKNOWN;
                     if (unknown_count != 8'hFF) unknown_count <= unknown_count + 8'd1;
                  end
               end
            end
            BUSY: begin
               if (wd != WD_W'(TIMEOUT_CYCLES)) wd <= wd + WD_W'(1);
               if (to_hit && (timeout_count != 8'hFF)) timeout_count <= timeout_count + 8'd1;
               if (done_c || to_hit) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bridge_cmd_dispatch.sv
// Scoreboard bench for bridge_cmd_dispatch: directed commands push expected
// completions and start pulses; a negedge monitor pops and compares them.
module tb_bridge_cmd_dispatch;

   localparam int unsigned N = 4;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                cmd_valid;
   logic [15:0]         cmd_word;
   logic                cmd_done;
   logic [15:0]         cmd_result;
   logic [31:0]         cmd_response;
   logic [N-1:0]        chan_enable;
   logic [N-1:0]        chan_valid;
   logic [N-1:0]        chan_done;
   logic [N*16-1:0]     chan_result;
   logic [N*32-1:0]     chan_response;
   logic                busy;
   logic [1:0]          active_idx;
   logic [7:0]          timeout_count;
   logic [7:0]          unknown_count;

   typedef struct packed {
      logic [15:0] res;
      logic [31:0] rsp;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  ch_q[$];
   exp_t        mon_e;
   logic [3:0]  mon_ch;
   int          checks = 0;
   int          errors = 0;
   int          lat;

   bridge_cmd_dispatch #(
      .N_CHAN(N), .WORD_W(16), .RESULT_W(16), .RESP_W(32),
      .CMD_WORDS(64'h0080_0080_0040_0010),
      .TIMEOUT_CYCLES(10),
      .TIMEOUT_RESULT(16'h0002),
      .UNKNOWN_RESULT(16'h0001)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_word(cmd_word),
      .cmd_done(cmd_done), .cmd_result(cmd_result), .cmd_response(cmd_response),
      .chan_enable(chan_enable), .chan_valid(chan_valid), .chan_done(chan_done),
      .chan_result(chan_result), .chan_response(chan_response),
      .busy(busy), .active_idx(active_idx),
      .timeout_count(timeout_count), .unknown_count(unknown_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every completion and every start pulse must match the next expectation
   always @(negedge clk) begin
      if (reset_n) begin
         if (cmd_done) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cmd_done: got result %h with no expectation", cmd_result);
            end else begin
               mon_e = exp_q.pop_front();
               check("cmd_result", 32'(cmd_result), 32'(mon_e.res));
               check("cmd_response", cmd_response, mon_e.rsp);
            end
         end
         if (chan_valid != '0) begin
            if (ch_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_chan_valid: got %b with no expectation", chan_valid);
            end else begin
               mon_ch = ch_q.pop_front();
               check("chan_valid", 32'(chan_valid), 32'(mon_ch));
            end
         end
      end
   end

   // Issue one command, hold it until done, return cycles from accept to cmd_done
   task automatic issue(input logic [15:0] w, input logic [15:0] er, input logic [31:0] ersp,
                        input logic [3:0] eoh, output int l);
      exp_t e;
      e.res = er;
      e.rsp = ersp;
      exp_q.push_back(e);
      if (eoh != 4'b0000) ch_q.push_back(eoh);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_word  = w;
      @(posedge clk);
      l = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (cmd_done) begin
            l = k;
            break;
         end
         @(posedge clk);
      end
      if (l < 0) begin
         checks++; errors++;
         $display("FAIL done_wait: got no cmd_done within 40 cycles for word %h", w);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Raise chan_done[ch] a fixed number of cycles after that channel's start pulse
   task automatic raise_done_after(input int ch, input int dly, input logic mangle);
      bit seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (chan_valid[ch]) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL pulse_wait: got no chan_valid[%0d] within 20 cycles", ch);
      end else begin
         if (mangle) begin
            @(posedge clk); #1;
            cmd_word    = 16'h9999;
            chan_enable = 4'b0000;
            dly = dly - 1;
         end
         repeat (dly) @(posedge clk);
         #1 chan_done[ch] = 1'b1;
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      cmd_valid     = 1'b0;
      cmd_word      = 16'h0000;
      chan_enable   = 4'b1111;
      chan_done     = 4'b0000;
      chan_result   = {16'h0033, 16'h0003, 16'h0007, 16'h0011};
      chan_response = {32'hCAFE_0003, 32'h1234_5678, 32'hDEAD_BEEF, 32'hA5A5_0000};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_done", 32'(cmd_done), 32'd0);
      check("rst_cmd_result", 32'(cmd_result), 32'd0);
      check("rst_cmd_response", cmd_response, 32'd0);
      check("rst_chan_valid", 32'(chan_valid), 32'd0);
      check("rst_active_idx", 32'(active_idx), 32'd0);
      check("rst_counts", {16'd0, timeout_count, unknown_count}, 32'd0);
      reset_n = 1'b1;

      // Tied-high done on channel 2: completes in the first BUSY cycle
      chan_done = 4'b0100;
      issue(16'h0080, 16'h0003, 32'h1234_5678, 4'b0100, lat);
      check("tie_latency", 32'(lat), 32'd1);
      check("tie_active_idx", 32'(active_idx), 32'd2);
      @(negedge clk);
      check("tie_busy_n2", 32'(busy), 32'd0);
      check("idle_result_zero", 32'(cmd_result), 32'd0);
      check("idle_response_zero", cmd_response, 32'd0);
      chan_done = 4'b0000;

      // Delayed done on channel 1, with word/enable churn mid-command
      fork
         issue(16'h0040, 16'h0007, 32'hDEAD_BEEF, 4'b0010, lat);
         raise_done_after(1, 5, 1'b1);
      join
      chan_done   = 4'b0000;
      chan_enable = 4'b1111;
      check("delay_latency", 32'(lat), 32'd6);
      check("delay_timeout_count", 32'(timeout_count), 32'd0);

      // Watchdog expiry on channel 1
      issue(16'h0040, 16'h0002, 32'h0, 4'b0010, lat);
      check("to_latency", 32'(lat), 32'd11);
      @(negedge clk);
      check("to_busy_after", 32'(busy), 32'd0);
      check("to_timeout_count", 32'(timeout_count), 32'd1);

      // Channel done lands exactly at the watchdog limit: channel wins
      fork
         issue(16'h0010, 16'h0011, 32'hA5A5_0000, 4'b0001, lat);
         raise_done_after(0, 10, 1'b0);
      join
      chan_done = 4'b0000;
      check("race_latency", 32'(lat), 32'd11);
      check("race_timeout_count", 32'(timeout_count), 32'd1);

      // Unknown word
      issue(16'h9999, 16'h0001, 32'h0, 4'b0000, lat);
      check("unk_latency", 32'(lat), 32'd1);
      check("unk_count", 32'(unknown_count), 32'd1);

      // Matching word on a disabled channel
      chan_enable = 4'b1110;
      issue(16'h0010, 16'h0001, 32'h0, 4'b0000, lat);
      check("dis_count", 32'(unknown_count), 32'd2);

      // Duplicate code with channel 2 disabled falls through to channel 3
      chan_enable = 4'b1011;
      chan_done   = 4'b1000;
      issue(16'h0080, 16'h0033, 32'hCAFE_0003, 4'b1000, lat);
      check("dup_latency", 32'(lat), 32'd1);
      check("dup_active_idx", 32'(active_idx), 32'd3);
      chan_enable = 4'b1111;
      chan_done   = 4'b0000;

      // Reset asserted mid-BUSY
      ch_q.push_back(4'b0010);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_word  = 16'h0040;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      #2;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cmd_done", 32'(cmd_done), 32'd0);
      check("abort_chan_valid", 32'(chan_valid), 32'd0);
      check("abort_counts", {16'd0, timeout_count, unknown_count}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Saturation of the unknown counter
      for (int i = 0; i < 300; i++) begin
         issue(16'h9999, 16'h0001, 32'h0, 4'b0000, lat);
      end
      @(negedge clk);
      check("unk_saturate", 32'(unknown_count), 32'd255);

      repeat (3) @(posedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("ch_q_drained", 32'(ch_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by %0t", $time);
      $fatal(1, "bench did not finish");
   end

endmodule
